mem_access_unit: RTL and testbench

//  Load/store and fetch engine between control/datapath and the unified word-wide sync-read memory.

---
 rtl/mem_access_unit_if.sv | 47 ++++
 rtl/mem_access_unit.sv | 198 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Request/response and memory-side bus of the memory access
//                unit. The slave modport is the unit itself; the master
//                modport is the requesting control logic together with the
//                word-wide synchronous-read memory.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int MEM_AW = 12
) ();

    // Request from control/datapath
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;

    // Completion back to control/datapath
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    // Word-wide synchronous-read memory
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Single-outstanding load/store/fetch engine in front of a
//                word-wide synchronous-read memory. Performs byte/half lane
//                extraction with sign or zero extension on loads, and a
//                read-modify-write sequence for sub-word stores because the
//                memory has no byte enables. Misaligned or illegal requests
//                are answered with an error and never touch memory.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit #(
    parameter int MEM_AW = 12
) (
    input  logic                   clk,
    input  logic                   reset,   // asynchronous, active-low
    mem_access_unit_if.slave       bus
);

    // ------------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD      = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR      = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    localparam logic [2:0] C_F3_B  = 3'b000;
    localparam logic [2:0] C_F3_H  = 3'b001;
    localparam logic [2:0] C_F3_W  = 3'b010;
    localparam logic [2:0] C_F3_BU = 3'b100;
    localparam logic [2:0] C_F3_HU = 3'b101;

    // ------------------------------------------------------------------------
    // State and latched request
    // ------------------------------------------------------------------------
    logic [2:0]        state_q,  state_d;
    logic [MEM_AW+1:0] addr_q,   addr_d;    // byte address within memory
    logic [2:0]        funct3_q, funct3_d;
    logic              write_q,  write_d;
    logic [31:0]       wdata_q,  wdata_d;   // store data, replaced by merged word for SB/SH
    logic [31:0]       rdata_q,  rdata_d;   // extended load result
    logic              err_q,    err_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic        w_accept;
    logic        w_bad_f3;
    logic        w_misalign;
    logic        w_req_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_extract;
    logic [31:0] w_merge;

    // Address bits above the memory size wrap; they are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:MEM_AW+2];

    // A request is taken only while the unit is idle.
    assign w_accept = bus.req_valid && (state_q == S_IDLE);

    // Legality of the incoming request: size code and natural alignment.
    always_comb begin
        if (bus.req_write) begin
            w_bad_f3 = (bus.req_funct3 > C_F3_W);
        end else begin
            w_bad_f3 = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
        end
        w_misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        w_req_err  = w_bad_f3 || w_misalign;
    end

    // Select the addressed byte/half of the returned word and extend it.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    w_byte = bus.mem_rdata[7:0];
            2'd1:    w_byte = bus.mem_rdata[15:8];
            2'd2:    w_byte = bus.mem_rdata[23:16];
            default: w_byte = bus.mem_rdata[31:24];
        endcase
        w_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (funct3_q)
            C_F3_B:  w_extract = {{24{w_byte[7]}}, w_byte};
            C_F3_BU: w_extract = {24'h000000, w_byte};
            C_F3_H:  w_extract = {{16{w_half[15]}}, w_half};
            C_F3_HU: w_extract = {16'h0000, w_half};
            default: w_extract = bus.mem_rdata;
        endcase
    end

    // Overlay the store byte/half onto the old word; other lanes preserved.
    always_comb begin
        w_merge = bus.mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            w_merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            w_merge[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        state_d = S_RESP;
                    end else if (bus.req_write && (bus.req_funct3 == C_F3_W)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:      state_d = S_RD_WAIT;
            S_RD_WAIT: state_d = write_q ? S_WR : S_RESP;
            S_WR:      state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM: outputs, strobes decoded from state, data from latched registers
    always_comb begin
        bus.req_ready  = (state_q == S_IDLE);
        bus.resp_valid = (state_q == S_RESP);
        bus.mem_rd_en  = (state_q == S_RD);
        bus.mem_wr_en  = (state_q == S_WR);
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
        bus.mem_addr   = addr_q[MEM_AW+1:2];
        bus.mem_wdata  = wdata_q;
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // Latch the request on accept; capture read data in RD_WAIT.
    always_comb begin
        addr_d   = addr_q;
        funct3_d = funct3_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        if (w_accept) begin
            addr_d   = bus.req_addr[MEM_AW+1:0];
            funct3_d = bus.req_funct3;
            write_d  = bus.req_write;
            wdata_d  = bus.req_wdata;
            rdata_d  = 32'h0000_0000;
            err_d    = w_req_err;
        end else if (state_q == S_RD_WAIT) begin
            if (write_q) begin
                wdata_d = w_merge;
            end else begin
                rdata_d = w_extract;
            end
        end
    end

    // Datapath flops, cleared by reset so an aborted operation leaves no trace.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            funct3_q <= 3'b000;
            write_q  <= 1'b0;
            wdata_q  <= 32'h0000_0000;
            rdata_q  <= 32'h0000_0000;
            err_q    <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Directed self-checking bench for mem_access_unit. A bench
//                memory answers the unit's strobes; a request-level model
//                predicts strobes, response timing and data per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int MEM_AW = 12;
    localparam int DEPTH  = 1 << MEM_AW;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit_if #(.MEM_AW(MEM_AW)) ifc ();

    mem_access_unit #(.MEM_AW(MEM_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Physical memory seen by the DUT, and the model's view of its contents
    logic [31:0] mem     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];

    always @(posedge clk) begin
        if (ifc.mem_rd_en) ifc.mem_rdata <= mem[ifc.mem_addr];
        if (ifc.mem_wr_en) mem[ifc.mem_addr] <= ifc.mem_wdata;
    end

    // Expected events, keyed by absolute cycle number
    logic [31:0] exp_rdata   [int];
    logic        exp_err     [int];
    int          exp_rd_addr [int];
    int          exp_wr_addr [int];
    logic [31:0] exp_wr_data [int];
    int          busy_until = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model's predictions
    always @(negedge clk) begin
        int n;
        n = cyc;
        chk("req_ready", {31'd0, ifc.req_ready}, {31'd0, (n > busy_until)});
        if (exp_rdata.exists(n)) begin
            chk("resp_valid", {31'd0, ifc.resp_valid}, 32'd1);
            chk("resp_rdata", ifc.resp_rdata, exp_rdata[n]);
            chk("resp_err", {31'd0, ifc.resp_err}, {31'd0, exp_err[n]});
            exp_rdata.delete(n);
            exp_err.delete(n);
        end else begin
            chk("resp_valid_idle", {31'd0, ifc.resp_valid}, 32'd0);
        end
        if (exp_rd_addr.exists(n)) begin
            chk("mem_rd_en", {31'd0, ifc.mem_rd_en}, 32'd1);
            chk("rd_addr", {20'd0, ifc.mem_addr}, exp_rd_addr[n]);
            exp_rd_addr.delete(n);
        end else begin
            chk("mem_rd_en_idle", {31'd0, ifc.mem_rd_en}, 32'd0);
        end
        if (exp_wr_addr.exists(n)) begin
            chk("mem_wr_en", {31'd0, ifc.mem_wr_en}, 32'd1);
            chk("wr_addr", {20'd0, ifc.mem_addr}, exp_wr_addr[n]);
            chk("wr_data", ifc.mem_wdata, exp_wr_data[n]);
            ref_mem[exp_wr_addr[n]] = exp_wr_data[n];
            exp_wr_addr.delete(n);
            exp_wr_data.delete(n);
        end else begin
            chk("mem_wr_en_idle", {31'd0, ifc.mem_wr_en}, 32'd0);
        end
    end

    task automatic poke(input int idx, input logic [31:0] v);
        mem[idx]     = v;
        ref_mem[idx] = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},  {31'd0, ifc.req_ready},  32'd1);
        chk({tag, "_valid"},  {31'd0, ifc.resp_valid}, 32'd0);
        chk({tag, "_rd_en"},  {31'd0, ifc.mem_rd_en},  32'd0);
        chk({tag, "_wr_en"},  {31'd0, ifc.mem_wr_en},  32'd0);
        chk({tag, "_addr"},   {20'd0, ifc.mem_addr},   32'd0);
        chk({tag, "_wdata"},  ifc.mem_wdata,           32'd0);
        chk({tag, "_rdata"},  ifc.resp_rdata,          32'd0);
        chk({tag, "_err"},    {31'd0, ifc.resp_err},   32'd0);
    endtask

    // Issue one request, predict its behaviour, optionally check a literal
    // result, hold req_valid while busy, or abort with reset after 'abort' cycles.
    task automatic do_req(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input bit has_lit, input logic [31:0] lit,
                          input bit busy_poke, input int abort);
        int a, sz, off, idx, resp, waitn;
        bit legal;
        logic [31:0] word, mask, val;
        @(negedge clk); #1;
        ifc.req_valid  = 1'b1;
        ifc.req_write  = wr;
        ifc.req_funct3 = f3;
        ifc.req_addr   = addr;
        ifc.req_wdata  = wd;
        waitn = 0;
        while (!ifc.req_ready && waitn < 20) begin
            @(negedge clk); #1;
            waitn++;
        end
        if (!ifc.req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1 within 20 cycles");
            ifc.req_valid = 1'b0;
            return;
        end
        a = cyc;

        idx = int'((addr >> 2) & (DEPTH - 1));
        off = int'(addr & 32'd3);
        case (f3[1:0])
            2'd0:    sz = 1;
            2'd1:    sz = 2;
            2'd2:    sz = 4;
            default: sz = 0;
        endcase
        legal = wr ? (f3 <= 3'd2) : (sz != 0 && f3 != 3'd6);
        if (legal && (off % sz) != 0) legal = 1'b0;
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);

        if (!legal) begin
            resp = a + 1;
            exp_rdata[resp] = 32'h0;
            exp_err[resp]   = 1'b1;
        end else if (!wr) begin
            exp_rd_addr[a + 1] = idx;
            word = ref_mem[idx];
            val  = (word >> (8 * off)) & mask;
            if (f3 < 3'd4 && sz < 4 && val[8 * sz - 1]) val = val | ~mask;
            resp = a + 3;
            exp_rdata[resp] = val;
            exp_err[resp]   = 1'b0;
        end else if (sz == 4) begin
            exp_wr_addr[a + 1] = idx;
            exp_wr_data[a + 1] = wd;
            resp = a + 2;
            exp_rdata[resp] = 32'h0;
            exp_err[resp]   = 1'b0;
        end else begin
            exp_rd_addr[a + 1] = idx;
            word = ref_mem[idx];
            val  = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            exp_wr_addr[a + 3] = idx;
            exp_wr_data[a + 3] = val;
            resp = a + 4;
            exp_rdata[resp] = 32'h0;
            exp_err[resp]   = 1'b0;
        end
        busy_until = resp;

        @(negedge clk); #1;
        if (busy_poke) begin
            ifc.req_write  = ~wr;
            ifc.req_funct3 = 3'b010;
            ifc.req_addr   = addr + 32'h40;
            ifc.req_wdata  = 32'h0BAD_0BAD;
        end else begin
            ifc.req_valid = 1'b0;
        end

        if (abort >= 0) begin
            while (cyc < a + abort) begin
                @(negedge clk); #1;
            end
            reset = 1'b0;
            exp_rdata.delete();
            exp_err.delete();
            exp_rd_addr.delete();
            exp_wr_addr.delete();
            exp_wr_data.delete();
            busy_until = -1;
            #1;
            check_reset_outputs("abort");
            repeat (2) @(negedge clk);
            #1;
            reset = 1'b1;
            return;
        end

        while (cyc < resp) begin
            @(negedge clk); #1;
        end
        ifc.req_valid = 1'b0;
        if (has_lit) chk("lit_rdata", ifc.resp_rdata, lit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1);
    end

    initial begin
        ifc.req_valid  = 1'b0;
        ifc.req_write  = 1'b0;
        ifc.req_funct3 = 3'b000;
        ifc.req_addr   = 32'h0;
        ifc.req_wdata  = 32'h0;
        for (int i = 0; i < DEPTH; i++) poke(i, 32'h0);

        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b1;

        // Word load
        poke(4, 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, -1);

        // Sub-word loads with extension, and address wrap
        poke(4, 32'h80FF1234);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0, -1);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 1'b1, 32'h00000080, 1'b0, -1);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 1'b1, 32'hFFFF80FF, 1'b0, -1);
        do_req(1'b0, 3'b101, 32'h10, 32'h0, 1'b1, 32'h00001234, 1'b0, -1);
        do_req(1'b0, 3'b000, 32'h11, 32'h0, 1'b1, 32'h00000012, 1'b0, -1);
        do_req(1'b0, 3'b100, 32'h12, 32'h0, 1'b1, 32'h000000FF, 1'b0, -1);
        do_req(1'b0, 3'b001, 32'h10, 32'h0, 1'b1, 32'h00001234, 1'b0, -1);
        do_req(1'b0, 3'b010, 32'h4010, 32'h0, 1'b1, 32'h80FF1234, 1'b0, -1);

        // Read-modify-write stores
        poke(1, 32'h11223344);
        do_req(1'b1, 3'b000, 32'h05, 32'h000000AB, 1'b1, 32'h0, 1'b0, -1);
        chk("mem1_after_sb", mem[1], 32'h1122AB44);
        do_req(1'b1, 3'b001, 32'h06, 32'h0000BEEF, 1'b1, 32'h0, 1'b0, -1);
        chk("mem1_after_sh", mem[1], 32'hBEEFAB44);
        do_req(1'b1, 3'b000, 32'h04, 32'hFFFFFF01, 1'b0, 32'h0, 1'b0, -1);
        chk("mem1_after_sb0", mem[1], 32'hBEEFAB01);

        // Illegal and misaligned requests
        do_req(1'b0, 3'b001, 32'h03, 32'h0, 1'b1, 32'h0, 1'b0, -1);
        do_req(1'b1, 3'b010, 32'h02, 32'h12345678, 1'b1, 32'h0, 1'b0, -1);
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1'b0, -1);
        do_req(1'b1, 3'b100, 32'h10, 32'h0, 1'b1, 32'h0, 1'b0, -1);
        do_req(1'b0, 3'b010, 32'h11, 32'h0, 1'b1, 32'h0, 1'b0, -1);
        chk("mem0_untouched", mem[0], 32'h0);

        // Reset during RD_WAIT of a half store aborts it
        poke(2, 32'h55667788);
        do_req(1'b1, 3'b001, 32'h08, 32'h00001234, 1'b0, 32'h0, 1'b0, 2);
        chk("mem2_after_abort", mem[2], 32'h55667788);
        do_req(1'b0, 3'b010, 32'h08, 32'h0, 1'b1, 32'h55667788, 1'b0, -1);

        // Store then load back-to-back, with req_valid held and changed while busy
        do_req(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, -1);
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 32'hCAFEF00D, 1'b1, -1);
        chk("mem24_untouched", mem[24], 32'h0);

        repeat (3) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
